// File: rtl/boot_memory_arbiter.sv
// boot_memory_arbiter
// Sequences boot of the program loader and owns the single instruction-memory
// port. While loading, the loader drives the port. Once loaded, the CPU fetch
// path and the host debug path share the port under round-robin arbitration.
module boot_memory_arbiter #(
  parameter int AUTO_BOOT    = 1,
  parameter int LOAD_TIMEOUT = 256,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              boot_req,
  output logic              loader_reset,
  output logic              loader_start,
  input  logic              loader_complete,
  input  logic [ADDR_W-1:0] loader_addr,
  input  logic [DATA_W-1:0] loader_wdata,
  input  logic              loader_write,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_grant,
  output logic              cpu_hold,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_write,
  output logic              host_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              boot_done,
  output logic              load_error,
  output logic [5:0]        words_loaded
);

  // The timer must hold LOAD_TIMEOUT itself, because it can increment once
  // more on the cycle that leaves LOADING.
  localparam int               TMR_W      = $clog2(LOAD_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(LOAD_TIMEOUT - 1);
  localparam logic [5:0]       WORDS_MAX  = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDR_RESET,
    ST_LDR_START,
    ST_LOADING,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  // Set only while held in reset. It lets the first edge after release decide
  // whether to start booting on its own.
  logic             auto_pending_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [TMR_W-1:0] timer_next;
  logic [5:0]       words_reg;
  logic [5:0]       words_next;
  // 1 = the CPU won the most recent conflict; 0 = the host won it (reset value).
  logic             last_cpu_reg;
  logic             last_cpu_next;
  logic             loader_reset_reg;
  logic             loader_start_reg;
  logic             cpu_hold_reg;
  logic             boot_done_reg;
  logic             boot_done_next;
  logic             load_error_reg;
  logic             load_error_next;
  logic             both_req;

  assign both_req = cpu_req && host_req;

  // State register; the auto-boot request is consumed by the first edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      auto_pending_reg <= (AUTO_BOOT != 0);
    end else begin
      state_reg        <= state_next;
      auto_pending_reg <= 1'b0;
    end
  end

  // Next-state logic. The loader is never interrupted by boot_req, and completion beats timeout.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (boot_req || auto_pending_reg) begin
          state_next = ST_LDR_RESET;
        end
      end
      ST_LDR_RESET: state_next = ST_LDR_START;
      ST_LDR_START: state_next = ST_LOADING;
      ST_LOADING: begin
        if (loader_complete) begin
          state_next = ST_RUN;
        end else if (timer_reg == TIMER_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_RUN, ST_ERROR: begin
        if (boot_req) begin
          state_next = ST_LDR_RESET;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the load timer, word counter, sticky status flags and round-robin pointer.
  always_comb begin
    timer_next      = timer_reg;
    words_next      = words_reg;
    boot_done_next  = boot_done_reg;
    load_error_next = load_error_reg;
    last_cpu_next   = last_cpu_reg;

    if (state_reg == ST_LDR_START) begin
      timer_next = '0;
    end else if (state_reg == ST_LOADING) begin
      timer_next = timer_reg + 1'b1;
    end

    if (state_next == ST_LDR_RESET) begin
      words_next = '0;
    end else if (state_reg == ST_LOADING && loader_write && words_reg != WORDS_MAX) begin
      words_next = words_reg + 6'd1;
    end

    // Status flags survive until the next load begins.
    if (state_next == ST_LDR_RESET) begin
      boot_done_next  = 1'b0;
      load_error_next = 1'b0;
    end else begin
      if (state_next == ST_RUN) begin
        boot_done_next = 1'b1;
      end
      if (state_next == ST_ERROR) begin
        load_error_next = 1'b1;
      end
    end

    // The pointer moves only when both sides actually collided.
    if (state_reg == ST_RUN && both_req) begin
      last_cpu_next = cpu_grant;
    end
  end

  // Datapath registers. Loader controls are decoded from the next state so they line up with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_reg        <= '0;
      words_reg        <= '0;
      last_cpu_reg     <= 1'b0;
      loader_reset_reg <= 1'b1;
      loader_start_reg <= 1'b0;
      cpu_hold_reg     <= 1'b1;
      boot_done_reg    <= 1'b0;
      load_error_reg   <= 1'b0;
    end else begin
      timer_reg        <= timer_next;
      words_reg        <= words_next;
      last_cpu_reg     <= last_cpu_next;
      loader_reset_reg <= (state_next == ST_LDR_RESET);
      loader_start_reg <= (state_next == ST_LDR_START);
      cpu_hold_reg     <= (state_next != ST_RUN);
      boot_done_reg    <= boot_done_next;
      load_error_reg   <= load_error_next;
    end
  end

  // Same-cycle port mux. The loader owns the port in LOADING; otherwise the granted requester drives it.
  always_comb begin
    cpu_grant      = 1'b0;
    host_grant     = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;

    unique case (state_reg)
      ST_LOADING: begin
        mem_addr       = loader_addr;
        mem_write_data = loader_wdata;
        mem_write      = loader_write;
      end
      ST_RUN: begin
        if (both_req) begin
          cpu_grant  = !last_cpu_reg;
          host_grant = last_cpu_reg;
        end else begin
          cpu_grant  = cpu_req;
          host_grant = host_req;
        end
      end
      ST_IDLE, ST_ERROR: begin
        host_grant = host_req;
      end
      default: begin
      end
    endcase

    // A fetch only reads, so it contributes an address and never a write strobe.
    if (host_grant) begin
      mem_addr       = host_addr;
      mem_write_data = host_wdata;
      mem_write      = host_write;
    end else if (cpu_grant) begin
      mem_addr = cpu_addr;
    end
  end

  assign loader_reset = loader_reset_reg;
  assign loader_start = loader_start_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign boot_done    = boot_done_reg;
  assign load_error   = load_error_reg;
  assign words_loaded = words_reg;

endmodule

// File: doc/boot_memory_arbiter.md
# boot_memory_arbiter

Owns the 32 x 16 instruction memory write/read port and sequences system boot. Resets and starts the program loader and routes its writes into memory. Holds the CPU stalled until loading completes, then shares the memory port between CPU fetch and a host debug port. Supports re-load on request, and reports a load timeout.

## Interface
Parameters:
- AUTO_BOOT, 1: when 1, a load sequence starts automatically after reset release.
- LOAD_TIMEOUT, 256: maximum cycles allowed in LOADING before error.
- ADDR_W, 5: memory address width.
- DATA_W, 16: memory data width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- boot_req  in  1  single-cycle request to (re)load the program.
- loader_reset  out  1  active-high reset to the program loader.
- loader_start  out  1  one-cycle start pulse to the loader.
- loader_complete  in  1  loader done flag, level.
- loader_addr / loader_wdata / loader_write  in  ADDR_W / DATA_W / 1  loader memory write port.
- cpu_req  in  1  CPU fetch request.
- cpu_addr  in  ADDR_W  fetch address.
- cpu_grant  out  1  fetch owns the memory port this cycle.
- cpu_hold  out  1  CPU stall/reset; 1 whenever not in RUN.
- host_req / host_addr / host_wdata / host_write  in  1 / ADDR_W / DATA_W / 1  host debug port.
- host_grant  out  1  host owns the memory port this cycle.
- mem_addr / mem_write_data / mem_write  out  ADDR_W / DATA_W / 1  to instruction memory.
- boot_done  out  1  set on entry to RUN; cleared on entry to LDR_RESET.
- load_error  out  1  set on timeout; cleared on entry to LDR_RESET.
- words_loaded  out  6  count of loader writes in the current load, saturating at 32.

## Operation
States: IDLE, LDR_RESET, LDR_START, LOADING, RUN, ERROR.

State transitions:
- After reset release, the FSM goes to LDR_RESET if AUTO_BOOT=1, otherwise to IDLE.
- IDLE: boot_req -> LDR_RESET.
- LDR_RESET: loader_reset=1 for exactly one cycle, clear words_loaded, -> LDR_START.
- LDR_START: loader_start=1 for exactly one cycle, clear timer, -> LOADING.
- LOADING: loader owns the port and the timer increments each cycle.
  - loader_complete=1 -> RUN. This takes precedence over a timeout in the same cycle.
  - Timer reaches LOAD_TIMEOUT-1 -> ERROR.
- RUN: cpu_hold=0 and the CPU and host share the port. boot_req -> LDR_RESET.
- ERROR: load_error=1. boot_req -> LDR_RESET.
- boot_req is ignored in LDR_RESET, LDR_START and LOADING.

Port muxing (combinational from state and requests):
- LOADING:
  - mem_* comes from loader_*.
  - cpu_grant=0, host_grant=0.
  - Every loader_write=1 cycle increments words_loaded, saturating at 32.
- RUN, arbitration between CPU and host:
  - Only one requester: it is granted.
  - Both requesting: round-robin on a last_winner register, which updates only when both requested. last_winner resets to host, so the CPU wins the first conflict.
- IDLE / ERROR: only the host may be granted; cpu_grant=0.
- LDR_RESET / LDR_START: no grants; mem_write=0.
- mem_write = granted host_write, or loader_write in LOADING. A CPU grant never writes.
- With no grant, mem_addr=0, mem_write_data=0, mem_write=0.

Reset values (reset_n low, asynchronous):
- loader_reset=1, which holds the loader in reset.
- loader_start=0, cpu_hold=1, boot_done=0, load_error=0, words_loaded=0.
- Timer=0, last_winner=host.
- State: IDLE, re-evaluated on the first edge after release.
- Asserting reset_n mid-load aborts immediately. Memory contents are not defined by this block.

## Timing
- Registered outputs: state, loader_reset, loader_start, cpu_hold, boot_done, load_error, words_loaded.
- Combinational outputs: grants and mem_* (same-cycle path from requests).
- Boot latency with AUTO_BOOT=1, counting edges after reset release:
  - edge 1: LDR_RESET
  - edge 2: LDR_START
  - edge 3: LOADING
  - one edge after loader_complete is sampled high: RUN, cpu_hold=0, boot_done=1.
- Timeout: ERROR is entered LOAD_TIMEOUT cycles after LOADING entry if loader_complete never asserts.
- boot_req in RUN: cpu_hold=1 on the next edge. A host or CPU grant in that same request cycle still completes.

## Test plan
- AUTO_BOOT=1, loader writes 32 words then asserts complete -> words_loaded=32, boot_done=1, cpu_hold falls one cycle after complete, and each mem_write matches its loader word and address.
- Loader never completes, LOAD_TIMEOUT=16 -> load_error=1 exactly 16 cycles after LOADING entry, cpu_hold stays 1; a following boot_req reloads and clears load_error.
- RUN with cpu_req and host_req both held for 4 cycles -> grants alternate CPU, host, CPU, host, with only one grant per cycle.
- host_write addr=5 data=0xBEEF in IDLE -> mem_write=1, mem_addr=5, mem_write_data=0xBEEF. The same host_write issued during LOADING -> no host_grant, and the loader write passes through unaltered.
- boot_req in RUN -> loader_reset pulses for one cycle, then loader_start pulses for one cycle, then boot_done=0 and words_loaded=0 until the new load completes.
- reset_n asserted in LOADING at word 10 -> all outputs take their reset values immediately; after release, the boot sequence restarts from LDR_RESET.
